// File: rtl/compound_accum_sink.sv
// compound_accum_sink
//   Consumer of the compound message stream. Write messages load or add x
//   into a 32-bit accumulator and bump a saturating write counter. A read
//   message snapshots the accumulator and returns it on a blocking result
//   port; no further messages are accepted until that result is taken.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   b_in            message {mode, x, y}
//   b_in_sync       producer has a valid message on b_in
//   b_in_notify     block ready to accept a message (registered)
//   res_out         accumulator snapshot for a read message
//   res_out_sync    downstream ready to take res_out
//   res_out_notify  res_out valid (registered)
//   acc_out         current accumulator value
//   wr_cnt_out      number of accepted writes, saturating at all-ones
//   sat_flag        (ACC_SAT_EN only) sticky saturation indicator
//
// Build option
//   ACC_SAT_EN  when defined, the y = 1 addition is signed-saturating and the
//               sat_flag output is present.

package compound_accum_pkg;
    // Encodings other than MODE_READ are handled as writes.
    typedef enum logic [1:0] {
        MODE_WRITE = 2'd0,
        MODE_READ  = 2'd1
    } mode_t;

    typedef struct packed {
        mode_t       mode;
        logic [31:0] x;
        logic        y;
    } compound_type_t;
endpackage

module compound_accum_sink
    import compound_accum_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  compound_type_t       b_in,
    input  logic                 b_in_sync,
    output logic                 b_in_notify,
    output logic [31:0]          res_out,
    input  logic                 res_out_sync,
    output logic                 res_out_notify,
    output logic [31:0]          acc_out,
    output logic [CNT_W-1:0]     wr_cnt_out
`ifdef ACC_SAT_EN
    ,
    output logic                 sat_flag
`endif
);

    typedef enum logic {
        SECTION_RX = 1'b0,
        SECTION_TX = 1'b1
    } section_t;

    section_t          section_q, section_d;
    logic [31:0]       acc_q, acc_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [31:0]       res_q, res_d;
    logic [31:0]       sum;

`ifdef ACC_SAT_EN
    logic sat_q, sat_d;
    logic pos_ovf, neg_ovf;
`endif

    assign sum = acc_q + b_in.x;

`ifdef ACC_SAT_EN
    // Signed overflow: operands share a sign and the result sign differs.
    assign pos_ovf = !acc_q[31] && !b_in.x[31] &&  sum[31];
    assign neg_ovf =  acc_q[31] &&  b_in.x[31] && !sum[31];
`endif

    always_comb begin
        section_d = section_q;
        acc_d     = acc_q;
        wr_cnt_d  = wr_cnt_q;
        res_d     = res_q;
`ifdef ACC_SAT_EN
        sat_d     = sat_q;
`endif
        unique case (section_q)
            SECTION_RX: begin
                if (b_in_sync) begin
                    if (b_in.mode == MODE_READ) begin
                        res_d     = acc_q;
                        section_d = SECTION_TX;
                    end else begin
                        if (b_in.y) begin
`ifdef ACC_SAT_EN
                            if (pos_ovf) begin
                                acc_d = 32'h7FFF_FFFF;
                                sat_d = 1'b1;
                            end else if (neg_ovf) begin
                                acc_d = 32'h8000_0000;
                                sat_d = 1'b1;
                            end else begin
                                acc_d = sum;
                            end
`else
                            acc_d = sum;
`endif
                        end else begin
                            acc_d = b_in.x;
`ifdef ACC_SAT_EN
                            sat_d = 1'b0;
`endif
                        end
                        if (wr_cnt_q != '1) begin
                            wr_cnt_d = wr_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            SECTION_TX: begin
                if (res_out_sync) begin
                    section_d = SECTION_RX;
                end
            end
            default: section_d = SECTION_RX;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            section_q <= SECTION_RX;
            acc_q     <= '0;
            wr_cnt_q  <= '0;
            res_q     <= '0;
`ifdef ACC_SAT_EN
            sat_q     <= 1'b0;
`endif
        end else begin
            section_q <= section_d;
            acc_q     <= acc_d;
            wr_cnt_q  <= wr_cnt_d;
            res_q     <= res_d;
`ifdef ACC_SAT_EN
            sat_q     <= sat_d;
`endif
        end
    end

    // Handshake outputs decode straight from the section register.
    assign b_in_notify    = (section_q == SECTION_RX);
    assign res_out_notify = (section_q == SECTION_TX);
    assign res_out        = res_q;
    assign acc_out        = acc_q;
    assign wr_cnt_out     = wr_cnt_q;
`ifdef ACC_SAT_EN
    assign sat_flag       = sat_q;
`endif

endmodule

// File: tb/tb_compound_accum_sink.sv
module tb_compound_accum_sink;
    import compound_accum_pkg::*;

    logic           clk = 1'b0;
    logic           rst;
    compound_type_t b_in;
    logic           b_in_sync;
    logic           b_in_notify;
    logic [31:0]    res_out;
    logic           res_out_sync;
    logic           res_out_notify;
    logic [31:0]    acc_out;
    logic [7:0]     wr_cnt_out;
`ifdef ACC_SAT_EN
    logic           sat_flag;
`endif

    compound_accum_sink #(.CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .b_in          (b_in),
        .b_in_sync     (b_in_sync),
        .b_in_notify   (b_in_notify),
        .res_out       (res_out),
        .res_out_sync  (res_out_sync),
        .res_out_notify(res_out_notify),
        .acc_out       (acc_out),
        .wr_cnt_out    (wr_cnt_out)
`ifdef ACC_SAT_EN
        ,
        .sat_flag      (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_acc;
    logic [7:0]  exp_cnt;

    typedef struct {
        logic        sync;
        mode_t       mode;
        logic [31:0] x;
        logic        y;
        logic [31:0] exp_wrap;
        logic [31:0] exp_sat;
        logic        exp_flag;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Result scoreboard: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (!rst && res_out_notify && res_out_sync) begin
            if (sb.size() == 0) begin
                chk("res_unexpected", 32'd1, 32'd0);
            end else begin
                chk("res_out", res_out, sb.pop_front());
            end
        end
    end

    task automatic apply_vec(input int i);
        b_in_sync = vecs[i].sync;
        b_in      = '{mode: vecs[i].mode, x: vecs[i].x, y: vecs[i].y};
        step();
        b_in_sync = 1'b0;
`ifdef ACC_SAT_EN
        exp_acc = vecs[i].exp_sat;
        chk($sformatf("sat_flag[%0d]", i), 32'(sat_flag), 32'(vecs[i].exp_flag));
`else
        exp_acc = vecs[i].exp_wrap;
`endif
        exp_cnt = vecs[i].exp_cnt;
        chk($sformatf("acc[%0d]", i), acc_out, exp_acc);
        chk($sformatf("cnt[%0d]", i), 32'(wr_cnt_out), 32'(exp_cnt));
    endtask

    task automatic send_read();
        b_in      = '{mode: MODE_READ, x: 32'h0, y: 1'b0};
        b_in_sync = 1'b1;
        sb.push_back(exp_acc);
        step();
        b_in_sync = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, MODE_WRITE, 32'd5,         1'b0, 32'd10 - 32'd5,  32'd5,         1'b0, 8'd1};
        vecs[1] = '{1'b1, MODE_WRITE, 32'd7,         1'b1, 32'd12,          32'd12,        1'b0, 8'd2};
        vecs[2] = '{1'b1, MODE_WRITE, 32'hFFFF_FFFE, 1'b1, 32'd10,          32'd10,        1'b0, 8'd3};
        vecs[3] = '{1'b0, MODE_WRITE, 32'd55,        1'b0, 32'd10,          32'd10,        1'b0, 8'd3};
        vecs[4] = '{1'b1, MODE_WRITE, 32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF,   32'h7FFF_FFFF, 1'b0, 8'd4};
        vecs[5] = '{1'b1, MODE_WRITE, 32'd1,         1'b1, 32'h8000_0000,   32'h7FFF_FFFF, 1'b1, 8'd5};
        vecs[6] = '{1'b1, MODE_WRITE, 32'hFFFF_FFFF, 1'b1, 32'h7FFF_FFFF,   32'h7FFF_FFFE, 1'b1, 8'd6};
        vecs[7] = '{1'b1, mode_t'(2'd3), 32'd100,    1'b0, 32'd100,         32'd100,       1'b0, 8'd7};
        vecs[8] = '{1'b1, MODE_WRITE, 32'hFFFF_FED4, 1'b1, 32'hFFFF_FF38,   32'hFFFF_FF38, 1'b0, 8'd8};
        vecs[9] = '{1'b1, MODE_WRITE, 32'h8000_0000, 1'b1, 32'h7FFF_FF38,   32'h8000_0000, 1'b1, 8'd9};

        rst          = 1'b1;
        b_in         = '{mode: MODE_WRITE, x: 32'h0, y: 1'b0};
        b_in_sync    = 1'b0;
        res_out_sync = 1'b0;
        exp_acc      = '0;
        exp_cnt      = '0;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_b_in_notify", 32'(b_in_notify), 32'd1);
        chk("rst_res_notify",  32'(res_out_notify), 32'd0);
        chk("rst_acc",         acc_out, 32'd0);
        chk("rst_cnt",         32'(wr_cnt_out), 32'd0);
        chk("rst_res",         res_out, 32'd0);

        for (int i = 0; i < 4; i++) apply_vec(i);

        // Read, then stall the result for 4 cycles with a write pending on b_in.
        send_read();
        chk("rd_notify",   32'(res_out_notify), 32'd1);
        chk("rd_b_notify", 32'(b_in_notify), 32'd0);
        b_in      = '{mode: MODE_WRITE, x: 32'd999, y: 1'b0};
        b_in_sync = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("stall_res",      res_out, 32'd10);
            chk("stall_b_notify", 32'(b_in_notify), 32'd0);
            chk("stall_r_notify", 32'(res_out_notify), 32'd1);
            chk("stall_acc",      acc_out, 32'd10);
            chk("stall_cnt",      32'(wr_cnt_out), 32'd3);
        end
        res_out_sync = 1'b1;
        step();
        res_out_sync = 1'b0;
        b_in_sync    = 1'b0;
        chk("rel_b_notify", 32'(b_in_notify), 32'd1);
        chk("rel_r_notify", 32'(res_out_notify), 32'd0);
        chk("rel_acc",      acc_out, 32'd10);
        chk("rel_cnt",      32'(wr_cnt_out), 32'd3);

        for (int i = 4; i < 10; i++) apply_vec(i);

        // Minimum round trip: accept, then deliver, then ready again.
        res_out_sync = 1'b1;
        send_read();
        chk("rt_r_notify", 32'(res_out_notify), 32'd1);
        step();
        chk("rt_b_notify",  32'(b_in_notify), 32'd1);
        chk("rt_r_notify2", 32'(res_out_notify), 32'd0);
        res_out_sync = 1'b0;

        // Counter saturation: 2^8 + 3 writes total from here adds 259.
        b_in      = '{mode: MODE_WRITE, x: 32'd0, y: 1'b1};
        b_in_sync = 1'b1;
        for (int k = 0; k < 246; k++) step();
        chk("cnt_at_max", 32'(wr_cnt_out), 32'd255);
        for (int k = 0; k < 13; k++) step();
        b_in_sync = 1'b0;
        chk("cnt_sat", 32'(wr_cnt_out), 32'd255);
        chk("cnt_acc", acc_out, exp_acc);

        // Reset in the middle of a pending read.
        b_in      = '{mode: MODE_WRITE, x: 32'h1234, y: 1'b0};
        b_in_sync = 1'b1;
        step();
        exp_acc = 32'h1234;
        send_read();
        begin
            int unsigned waited = 0;
            while (!res_out_notify && waited < 8) begin
                step();
                waited++;
            end
            chk("mid_notify_seen", 32'(res_out_notify), 32'd1);
        end
        rst = 1'b1;
        #1;
        sb.delete();
        chk("mr_r_notify", 32'(res_out_notify), 32'd0);
        chk("mr_b_notify", 32'(b_in_notify), 32'd1);
        step();
        rst = 1'b0;
        step();
        chk("mr_acc",       acc_out, 32'd0);
        chk("mr_cnt",       32'(wr_cnt_out), 32'd0);
        chk("mr_res",       res_out, 32'd0);
        chk("mr_r_notify2", 32'(res_out_notify), 32'd0);
        chk("mr_b_notify2", 32'(b_in_notify), 32'd1);
`ifdef ACC_SAT_EN
        chk("mr_sat", 32'(sat_flag), 32'd0);
`endif
        chk("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
